lq_stq_rot_ctl: RTL

- Store-data alignment control stage sitting directly upstream of the per-slice store rotator array.
- Accepts store-data requests (size, lane offset, sign-extend flag, data, itag) through a valid/ready handshake.
- Decodes each request into the rotator controls: one-hot rot_sel, one-hot mask and active-low sign-fill se_b.
- Buffers decoded requests in a 2-entry FIFO so the rotator stage can stall without dropping ops; supports flush.

---
 rtl/lq_stq_rot_ctl_pkg.sv | 32 +++
 rtl/lq_stq_rot_ctl_if.sv | 32 +++
 rtl/lq_stq_rot_dec.sv | 40 ++++
 rtl/lq_stq_rot_ctl.sv | 85 ++++++++
 4 files changed

// File: rtl/lq_stq_rot_ctl_pkg.sv
// Shared types for the store-data rotator control stage: size codes, one-hot
// control constants (written [0:3], index 0 = no shift / 8B) and the decode result.
package lq_stq_rot_pkg;

  typedef enum logic [1:0] {
    SZ_1B = 2'b00,
    SZ_2B = 2'b01,
    SZ_4B = 2'b10,
    SZ_8B = 2'b11
  } size_e;

  typedef logic [0:3] oh4_t;

  localparam int   SLOTS_TOTAL = 8;
  localparam oh4_t ROT_NONE    = 4'b1000;
  localparam oh4_t MASK_8B     = 4'b1000;

  typedef struct packed {
    oh4_t rot_sel;
    oh4_t mask;
    logic se_b;
    logic err;
  } dec_t;

  localparam dec_t DEC_RST = '{rot_sel: ROT_NONE, mask: MASK_8B, se_b: 1'b1, err: 1'b0};

  // Slot count of a size code: 1, 2, 4 or 8 byte slices.
  function automatic logic [3:0] size_slots(logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lq_stq_rot_ctl_if.sv
// Request/response bundle between the store pipe, this control stage and the rotator array.
interface lq_stq_rot_ctl_if #(
  parameter int DATA_W = 64,
  parameter int ITAG_W = 7
);
  logic              in_val;
  logic              in_rdy;
  logic [1:0]        in_size;
  logic [1:0]        in_offset;
  logic              in_sext;
  logic [ITAG_W-1:0] in_itag;
  logic [DATA_W-1:0] in_data;

  logic              out_val;
  logic              out_rdy;
  logic [0:3]        out_rot_sel;
  logic [0:3]        out_mask;
  logic              out_se_b;
  logic              out_err;
  logic [ITAG_W-1:0] out_itag;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_val, in_size, in_offset, in_sext, in_itag, in_data, out_rdy,
    output in_rdy, out_val, out_rot_sel, out_mask, out_se_b, out_err, out_itag, out_data
  );

  modport master (
    output in_val, in_size, in_offset, in_sext, in_itag, in_data, out_rdy,
    input  in_rdy, out_val, out_rot_sel, out_mask, out_se_b, out_err, out_itag, out_data
  );
endinterface

// File: rtl/lq_stq_rot_dec.sv
// Combinational size/offset/sign decode into rotator shift select, size mask and sign fill.
module lq_stq_rot_dec
  import lq_stq_rot_pkg::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_offset,
  input  logic       i_sext,
  input  logic [2:0] i_sign,   // operand MSB for 1B/2B/4B: bits 7, 15, 31
  output dec_t       o_dec
);
  logic [3:0] w_span;
  logic       w_legal;
  logic       w_sign;
  oh4_t       w_rot;
  oh4_t       w_mask;

  always_comb begin
    w_span  = {1'b0, i_offset, 1'b0} + size_slots(i_size);
    w_legal = (w_span <= 4'(SLOTS_TOTAL));

    w_sign = 1'b0;
    case (i_size)
      SZ_1B:   w_sign = i_sign[0];
      SZ_2B:   w_sign = i_sign[1];
      SZ_4B:   w_sign = i_sign[2];
      default: w_sign = 1'b0;
    endcase

    w_rot            = '0;
    w_rot[i_offset]  = 1'b1;
    // mask index runs 8B..1B, i.e. the inverted size code
    w_mask           = '0;
    w_mask[~i_size]  = 1'b1;

    o_dec.err     = ~w_legal;
    o_dec.rot_sel = w_legal ? w_rot  : ROT_NONE;
    o_dec.mask    = w_legal ? w_mask : MASK_8B;
    o_dec.se_b    = ~(i_sext & w_sign & (i_size != SZ_8B) & w_legal);
  end
endmodule

// File: rtl/lq_stq_rot_ctl.sv
// Store-data alignment control: decodes requests and queues them in a 2-entry FIFO
// ahead of the rotator array; counts accepted illegal requests.
module lq_stq_rot_ctl
  import lq_stq_rot_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ITAG_W    = 7,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 flush,
  lq_stq_rot_ctl_if.slave      bus,
  output logic [1:0]           occ,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  typedef struct packed {
    dec_t              dec;
    logic [ITAG_W-1:0] itag;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam entry_t ENTRY_RST = '{dec: DEC_RST, itag: '0, data: '0};

  entry_t                 r_mem [2];
  logic                   r_wptr;
  logic                   r_rptr;
  logic [1:0]             r_occ;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  dec_t   w_dec;
  entry_t w_new;
  logic   w_push;
  logic   w_pop;

  lq_stq_rot_dec u_dec (
    .i_size   (bus.in_size),
    .i_offset (bus.in_offset),
    .i_sext   (bus.in_sext),
    .i_sign   ({bus.in_data[31], bus.in_data[15], bus.in_data[7]}),
    .o_dec    (w_dec)
  );

  assign w_new  = '{dec: w_dec, itag: bus.in_itag, data: bus.in_data};
  assign w_push = bus.in_val & bus.in_rdy;
  // a pop coinciding with flush is moot: everything is dropped anyway
  assign w_pop  = bus.out_val & bus.out_rdy & ~flush;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_mem[0]  <= ENTRY_RST;
      r_mem[1]  <= ENTRY_RST;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_occ     <= 2'd0;
      r_err_cnt <= '0;
    end else begin
      if (flush) begin
        r_wptr <= 1'b0;
        r_rptr <= 1'b0;
        r_occ  <= 2'd0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= w_new;
          r_wptr        <= ~r_wptr;
        end
        if (w_pop) r_rptr <= ~r_rptr;
        r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      end
      if (w_push && w_new.dec.err && !(&r_err_cnt))
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
    end
  end

  assign bus.in_rdy      = (r_occ != 2'd2) & ~flush;
  assign bus.out_val     = (r_occ != 2'd0);
  assign bus.out_rot_sel = r_mem[r_rptr].dec.rot_sel;
  assign bus.out_mask    = r_mem[r_rptr].dec.mask;
  assign bus.out_se_b    = r_mem[r_rptr].dec.se_b;
  assign bus.out_err     = r_mem[r_rptr].dec.err;
  assign bus.out_itag    = r_mem[r_rptr].itag;
  assign bus.out_data    = r_mem[r_rptr].data;
  assign occ             = r_occ;
  assign err_cnt         = r_err_cnt;
endmodule
